// File: rtl/cache_arbiter.sv
// Arbitrates the single pmem line port between the icache and dcache, one transaction at a time.
// Grant to strobe 1 cycle; resp/rdata combinational on pmem_resp; requesters hold requests until their resp.
module cache_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    state_t                state_q;
    logic                  pmem_read_q;
    logic                  pmem_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [3:0]            d_streak_q;
    logic [3:0]            d_streak_d;

    logic idle;
    logic d_req;
    logic i_starved;
    logic grant_d;
    logic grant_i;

    assign idle      = (state_q == IDLE);
    assign d_req     = d_read | d_write;
    assign i_starved = i_read && (d_streak_q >= MAX_STREAK);
    assign grant_d   = idle && d_req && !i_starved;
    assign grant_i   = idle && i_read && !grant_d;

    // The streak only counts D grants that actually made I wait.
    always_comb begin
        d_streak_d = d_streak_q;
        if (grant_d && i_read) begin
            d_streak_d = (d_streak_q == 4'hF) ? 4'hF : d_streak_q + 4'd1;
        end else if (grant_d || grant_i) begin
            d_streak_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            d_streak_q   <= 4'd0;
        end else begin
            d_streak_q <= d_streak_d;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        // Read+write together is illegal upstream; the writeback wins.
                        state_q      <= SERVE_D;
                        pmem_write_q <= d_write;
                        pmem_read_q  <= !d_write;
                        addr_q       <= d_address;
                        wdata_q      <= d_wdata;
                    end else if (grant_i) begin
                        state_q      <= SERVE_I;
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                        addr_q       <= i_address;
                        wdata_q      <= d_wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_q      <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == SERVE_I) && pmem_resp;
    assign d_resp  = (state_q == SERVE_D) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the pipeline's instruction cache and data cache.
- Accepts line-fill, read and writeback requests from both caches and issues exactly one pmem transaction at a time.
- Routes the response back to the requester that owns the transaction.
- Sits between the I/D caches and the memory model, below the pipelined datapath and its control ROM.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, line address width.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced ahead (range 1..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_read  input  1  icache line read request.
- i_address  input  ADDR_WIDTH  icache line address.
- i_rdata  output  LINE_WIDTH  read line to icache.
- i_resp  output  1  icache transaction complete.
- d_read  input  1  dcache line read request.
- d_write  input  1  dcache line writeback request.
- d_address  input  ADDR_WIDTH  dcache line address.
- d_wdata  input  LINE_WIDTH  dcache writeback line.
- d_rdata  output  LINE_WIDTH  read line to dcache.
- d_resp  output  1  dcache transaction complete.
- pmem_read  output  1  memory read strobe.
- pmem_write  output  1  memory write strobe.
- pmem_address  output  ADDR_WIDTH  memory line address.
- pmem_wdata  output  LINE_WIDTH  memory write line.
- pmem_rdata  input  LINE_WIDTH  memory read line.
- pmem_resp  input  1  memory transaction complete.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- State machine: IDLE, SERVE_I, SERVE_D. Registers: state, latched op (read/write), latched address and wdata, and a 4-bit d_streak counter.
- Reset effects: state=IDLE, d_streak=0, latches cleared. All outputs are 0 in the cycle after reset is sampled. A reset mid-transaction abandons it: pmem_read/pmem_write drop on the next cycle, and no resp is delivered.
- Request sampling: requests are sampled only in IDLE.
  - Grant D if (d_read|d_write) and not (i_read and d_streak>=MAX_D_STREAK).
  - Otherwise grant I if i_read.
  - Otherwise stay in IDLE.
- d_streak updates:
  - A D grant while i_read=1 increments d_streak, saturating at 15.
  - An I grant, or a D grant with i_read=0, clears d_streak.
- Grant latching: on grant, latch address, d_wdata, and op. d_read and d_write both high is illegal; treat it as a write. The state moves to SERVE_x on the next edge.
- Latency: request visible in IDLE at cycle N, then pmem_read or pmem_write is high from cycle N+1.
- SERVE_x:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are driven from the latches only, never from live requester inputs.
  - The strobe is held until pmem_resp.
- Response cycle: in the cycle pmem_resp=1 in SERVE_x:
  - x_resp=1 for exactly that cycle, combinationally.
  - x_rdata=pmem_rdata. d_rdata is don't-care on writes.
  - The next state is IDLE.
- Mandatory IDLE cycle: after every response there is at least one IDLE cycle. The requester deasserts its request there, so a stale request is never re-granted.
- pmem_resp outside SERVE_x is ignored.
- i_rdata/d_rdata are 0 when not responding.
- Invariants:
  - pmem_read and pmem_write are never high together.
  - i_resp and d_resp are never high together.
  - Requester inputs changing during SERVE_x have no effect.

Test Plan:
- Single I read: i_read=1, addr 0x0000_0040; memory responds after 5 cycles with line A.
  - pmem_read high from cycle 1, pmem_address=0x40.
  - i_resp=1 one cycle with i_rdata=A.
  - IDLE on the following cycle.
- D writeback: d_write=1, addr 0x0000_1000, wdata B.
  - pmem_write=1, pmem_wdata=B until pmem_resp.
  - d_resp pulses once; i_resp stays 0.
- Simultaneous: i_read and d_read asserted in the same cycle.
  - D served first.
  - One IDLE cycle, then I served.
  - Exactly one resp pulse to each requester.
- Starvation: i_read held continuously while d_read is reasserted immediately after each response.
  - With MAX_D_STREAK=4, grants go D,D,D,D,I.
  - d_streak then returns to 0.
- Address change mid-serve: change d_address from 0x100 to 0x200 during SERVE_D.
  - pmem_address stays at 0x100.
- Reset mid-operation: rst=1 while in SERVE_I with pmem_read=1.
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent stray pmem_resp produces no i_resp or d_resp.
